// File: rtl/servo_pkg.sv
// Shared types and default timing constants for the servo PWM generator.
package servo_pkg;

  // Frame controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Width of the frame counter and of every high-time quantity.
  localparam int unsigned CNT_W = 20;

  // 50 MHz clock: 20 ms frame, 0.5 ms minimum pulse, 2.5 ms maximum pulse.
  localparam int unsigned DEF_PERIOD   = 1_000_000;
  localparam int unsigned DEF_MIN_HIGH = 25_000;
  localparam int unsigned DEF_MAX_HIGH = 125_000;

endpackage

// File: rtl/servo_clamp.sv
// Combinational saturation of a requested pulse width into [min, max].
// A request of zero is passed through as zero (servo switched off) and is
// not reported as clamped.
module servo_clamp
  import servo_pkg::*;
(
  input  logic [CNT_W-1:0] value,
  input  logic [CNT_W-1:0] min,
  input  logic [CNT_W-1:0] max,
  output logic [CNT_W-1:0] result,
  output logic             clamped
);

  // Choose the saturated width and flag whether it differs from the request.
  always_comb begin
    result  = value;
    clamped = 1'b0;
    if (value == '0) begin
      result  = '0;
      clamped = 1'b0;
    end else if (value < min) begin
      result  = min;
      clamped = 1'b1;
    end else if (value > max) begin
      result  = max;
      clamped = 1'b1;
    end
  end

endmodule

// File: rtl/servo_pwm.sv
// Servo pulse generator: back-to-back frames of PERIOD cycles, pulse width
// latched (and saturated) once per frame, graceful drain when en drops.
module servo_pwm
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD   = DEF_PERIOD,
  parameter int unsigned MIN_HIGH = DEF_MIN_HIGH,
  parameter int unsigned MAX_HIGH = DEF_MAX_HIGH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] fre_need,
  output logic             pwm_out,
  output logic             frame_start,
  output logic [CNT_W-1:0] fre_hold,
  output logic             clamped,
  output logic             busy
);

  // Reject parameter sets the counter or the clamp cannot honour.
  if (PERIOD < 1 || PERIOD > (2 ** CNT_W) || MIN_HIGH > MAX_HIGH || MAX_HIGH >= PERIOD) begin : g_bad_params
    $error("servo_pwm: illegal parameters, need MIN_HIGH <= MAX_HIGH < PERIOD <= 2**20");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] MIN_V    = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] MAX_V    = CNT_W'(MAX_HIGH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_start;
  logic             w_last;
  logic [CNT_W-1:0] r_hold;
  logic [CNT_W-1:0] w_hold_nxt;
  logic             r_clamped;
  logic             w_clamped_nxt;
  logic             r_pwm;
  logic             w_pwm_nxt;
  logic             r_frame_start;
  logic [CNT_W-1:0] w_sat;
  logic             w_sat_clamped;

  // Saturated version of the current request; only used on frame starts.
  servo_clamp u_clamp (
    .value   (fre_need),
    .min     (MIN_V),
    .max     (MAX_V),
    .result  (w_sat),
    .clamped (w_sat_clamped)
  );

  assign w_last = (r_cnt == LAST_CNT);

  // Next state, next counter and next registered outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_nxt = ST_RUN;
          w_start     = 1'b1;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (w_last) begin
          // Frame boundary: continue only if still requested.
          if (en) begin
            w_state_nxt = ST_RUN;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          w_state_nxt = en ? ST_RUN : ST_DRAIN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_hold_nxt    = w_start ? w_sat : r_hold;
    w_clamped_nxt = w_start ? w_sat_clamped : r_clamped;
    w_pwm_nxt     = (w_state_nxt != ST_IDLE) && (w_cnt_nxt < w_hold_nxt);
  end

  // State, counter and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_hold        <= '0;
      r_clamped     <= 1'b0;
      r_pwm         <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_hold        <= w_hold_nxt;
      r_clamped     <= w_clamped_nxt;
      r_pwm         <= w_pwm_nxt;
      r_frame_start <= w_start;
    end
  end

  assign pwm_out     = r_pwm;
  assign frame_start = r_frame_start;
  assign fre_hold    = r_hold;
  assign clamped     = r_clamped;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_servo_pwm.sv
// Bench for servo_pwm with short frames: directed scenarios plus random
// traffic, every cycle compared against a frame-level reference model.
module tb_servo_pwm;

  localparam int P  = 100;
  localparam int MN = 10;
  localparam int MX = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [19:0] fre_need;
  logic        pwm_out;
  logic        frame_start;
  logic [19:0] fre_hold;
  logic        clamped;
  logic        busy;

  always #5 clk = ~clk;

  servo_pwm #(.PERIOD(P), .MIN_HIGH(MN), .MAX_HIGH(MX)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .fre_need    (fre_need),
    .pwm_out     (pwm_out),
    .frame_start (frame_start),
    .fre_hold    (fre_hold),
    .clamped     (clamped),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: is a frame in progress, where in it, and its pulse width.
  bit m_in    = 1'b0;
  int m_pos   = 0;
  int m_hold  = 0;
  bit m_clamp = 1'b0;
  bit m_fs    = 1'b0;

  bit mon_en    = 1'b0;
  bit have_prev = 1'b0;
  int gap       = 0;
  int hcnt      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void sat(input int v, output int h, output bit c);
    if (v == 0) begin h = 0; c = 1'b0; end
    else if (v < MN) begin h = MN; c = 1'b1; end
    else if (v > MX) begin h = MX; c = 1'b1; end
    else begin h = v; c = 1'b0; end
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_in = 1'b0; m_pos = 0; m_hold = 0; m_clamp = 1'b0; m_fs = 1'b0;
    end else if (m_in && m_pos < P - 1) begin
      m_pos++; m_fs = 1'b0;
    end else if (en) begin
      m_in = 1'b1; m_pos = 0; m_fs = 1'b1;
      sat(int'(fre_need), m_hold, m_clamp);
    end else begin
      m_in = 1'b0; m_pos = 0; m_fs = 1'b0;
    end
    #1;
    chk("pwm_out", pwm_out, (m_in && m_pos < m_hold) ? 1 : 0);
    chk("frame_start", frame_start, m_fs);
    chk("fre_hold", fre_hold, m_hold);
    chk("clamped", clamped, m_clamp);
    chk("busy", busy, m_in);
  endtask

  task automatic run(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      tick();
      hi += int'(pwm_out);
    end
  endtask

  // One full frame with a fixed request, checking latch and pulse length.
  task automatic frame_check(input string tag, input int need, input int exp_hi,
                             input int exp_hold, input bit exp_cl);
    int h0, h;
    fre_need = 20'(need);
    tick();
    h0 = int'(pwm_out);
    chk({tag, "_fs"}, frame_start, 1);
    chk({tag, "_hold"}, fre_hold, exp_hold);
    chk({tag, "_clamped"}, clamped, exp_cl);
    run(P - 1, h);
    chk({tag, "_high"}, h0 + h, exp_hi);
  endtask

  // Continuous checks: pulse never longer than MX, frame starts exactly P apart.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy !== 1'b1) begin
        have_prev = 1'b0;
        hcnt      = 0;
      end else begin
        if (frame_start === 1'b1) begin
          if (have_prev) chk("fs_spacing", gap, P);
          have_prev = 1'b1;
          gap       = 1;
          hcnt      = 0;
        end else begin
          gap++;
        end
        if (pwm_out === 1'b1) begin
          hcnt++;
          chk("high_le_max", (hcnt <= MX) ? 1 : 0, 1);
        end
      end
    end
  end

  initial begin
    int hi, h, fs_sum;
    rst = 1'b1; en = 1'b0; fre_need = '0;
    repeat (3) tick();
    chk("rst_pwm", pwm_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hold", fre_hold, 0);
    mon_en = 1'b1;

    // Basic frames, then a mid-frame request change.
    rst = 1'b0; en = 1'b1;
    frame_check("f30", 30, 30, 30, 1'b0);
    fre_need = 20'd30;
    tick();
    hi = int'(pwm_out);
    run(5, h); hi += h;
    fre_need = 20'd40;
    run(P - 6, h); hi += h;
    chk("chg_cur_high", hi, 30);
    frame_check("chg_next", 40, 40, 40, 1'b0);

    // Saturation rules.
    frame_check("zero", 0, 0, 0, 1'b0);
    frame_check("below_min", 4, 10, 10, 1'b1);
    frame_check("above_max", 200, 50, 50, 1'b1);

    // en drops at cnt=20: frame completes, then idle.
    fre_need = 20'd30;
    tick();
    hi = int'(pwm_out);
    run(19, h); hi += h;
    en = 1'b0;
    run(80, h); hi += h;
    chk("drain_high", hi, 30);
    chk("drain_busy_last", busy, 1);
    tick();
    chk("drain_idle_busy", busy, 0);
    fs_sum = 0;
    repeat (20) begin tick(); fs_sum += int'(frame_start); end
    chk("idle_no_fs", fs_sum, 0);

    // en re-asserted at cnt=60 while draining: no gap.
    en = 1'b1;
    tick();
    run(20, h);
    en = 1'b0;
    run(40, h);
    en = 1'b1;
    run(39, h);
    tick();
    chk("resume_no_gap", frame_start, 1);
    run(P - 1, h);

    // en back only in the last cycle of a draining frame.
    tick();
    run(9, h);
    en = 1'b0;
    run(89, h);
    en = 1'b1;
    tick();
    tick();
    chk("drain_last_restart", frame_start, 1);

    // Reset mid-pulse wins, also while en stays high.
    run(15, h);
    chk("pre_rst_pwm", pwm_out, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_pwm", pwm_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_hold", fre_hold, 0);
    tick();
    chk("rst_en_busy", busy, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_fs", frame_start, 1);
    run(P - 1, h);

    // Random traffic.
    repeat (3000) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 59) == 0) en = ~en;
      if ($urandom_range(0, 14) == 0) begin
        case ($urandom_range(0, 4))
          0: fre_need = '0;
          1: fre_need = 20'($urandom_range(1, MN - 1));
          2: fre_need = 20'($urandom_range(MN, MX));
          3: fre_need = 20'($urandom_range(MX + 1, 300));
          default: fre_need = 20'($urandom_range(0, 20'hFFFFF));
        endcase
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
